// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode rendering engine:
// command opcodes, blank cell defaults, the 16-colour palette and FSM states.
package text_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_PUT   = 8'h02;
    localparam logic [7:0] OP_ATTR  = 8'h03;
    localparam logic [7:0] OP_CLEAR = 8'h04;

    localparam logic [7:0] SPACE        = 8'h20;
    localparam logic [7:0] DEFAULT_ATTR = 8'h0F;

    localparam int CHAR_W_DEF = 7;

    typedef struct packed {
        logic [7:0]            attr;
        logic [CHAR_W_DEF-1:0] ch;
    } cell_t;

    // 4 bits per channel {r,g,b}, entry 15 first so entry i sits at [12*i +: 12]
    localparam logic [16*12-1:0] PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
        12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00,
        12'h0AA, 12'h0A0, 12'h00A, 12'h000
    };

    function automatic logic [11:0] palette_rgb(input logic [3:0] idx);
        return PALETTE[int'(idx)*12 +: 12];
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_COL,
        S_W_ROW,
        S_W_CHR,
        S_W_ATR,
        S_P_CHR,
        S_A_ATR,
        S_CLEAR
    } state_e;

endpackage

// File: rtl/text_cell_ram.sv
// Cell store: one write port, one registered read port, no reset.
// A same-address read and write in one cycle returns the old word.
module text_cell_ram #(
    parameter int DEPTH = 2400,
    parameter int AW    = 12,
    parameter int DW    = 15
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/text_engine.sv
// Text-mode renderer: UART byte command FSM with cursor and attribute,
// plus a three-stage cell -> glyph -> palette pixel pipeline.
module text_engine
    import text_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int C_WIDTH     = 8,
    parameter int C_HEIGHT    = 16,
    parameter int COLOR_WIDTH = 4,
    parameter int CHAR_WIDTH  = 7
) (
    input  logic                                     clk_i,
    input  logic                                     rstn_i,
    input  logic [7:0]                               rx_data_i,
    input  logic                                     rx_valid_i,
    input  logic [$clog2(H_RES)-1:0]                 x_i,
    input  logic [$clog2(V_RES)-1:0]                 y_i,
    input  logic                                     active_i,
    input  logic                                     hs_i,
    input  logic                                     vs_i,
    output logic [CHAR_WIDTH+$clog2(C_HEIGHT)-1:0]   font_addr_o,
    input  logic [C_WIDTH-1:0]                       font_row_i,
    output logic [COLOR_WIDTH-1:0]                   r_o,
    output logic [COLOR_WIDTH-1:0]                   g_o,
    output logic [COLOR_WIDTH-1:0]                   b_o,
    output logic                                     de_o,
    output logic                                     hs_o,
    output logic                                     vs_o,
    output logic                                     busy_o,
    output logic                                     err_o
);

    localparam int N_COL   = H_RES / C_WIDTH;
    localparam int N_ROW   = V_RES / C_HEIGHT;
    localparam int N_CELLS = N_COL * N_ROW;
    localparam int CELL_AW = $clog2(N_CELLS);
    localparam int FONT_AW = CHAR_WIDTH + $clog2(C_HEIGHT);
    localparam int CELL_W  = 8 + CHAR_WIDTH;
    localparam int COLW    = $clog2(N_COL);
    localparam int ROWW    = $clog2(N_ROW);
    localparam int GW      = $clog2(C_HEIGHT);
    localparam int PXW     = $clog2(C_WIDTH);

    function automatic logic [CELL_AW-1:0] cell_addr(
        input logic [ROWW-1:0] r,
        input logic [COLW-1:0] c
    );
        return CELL_AW'(r) * CELL_AW'(N_COL) + CELL_AW'(c);
    endfunction

    function automatic logic [ROWW+COLW-1:0] next_pos(
        input logic [ROWW-1:0] r,
        input logic [COLW-1:0] c
    );
        if (c != COLW'(N_COL - 1)) begin
            return {r, c + 1'b1};
        end
        if (r == ROWW'(N_ROW - 1)) begin
            return '0;
        end
        return {r + 1'b1, COLW'(0)};
    endfunction

    // Stretch a 4-bit palette channel to the output channel width
    function automatic logic [COLOR_WIDTH-1:0] chan(input logic [3:0] n);
        return COLOR_WIDTH'({4{n}} >> (16 - COLOR_WIDTH));
    endfunction

    state_e               state_q, state_d;
    logic                 rx_valid_q;
    logic                 rx_rise;
    logic [COLW-1:0]      cur_col_q, cur_col_d;
    logic [ROWW-1:0]      cur_row_q, cur_row_d;
    logic [7:0]           cur_attr_q, cur_attr_d;
    logic                 err_q, err_d;
    logic [7:0]           op_col_q, op_col_d;
    logic [7:0]           op_row_q, op_row_d;
    logic [CHAR_WIDTH-1:0] op_chr_q, op_chr_d;
    logic [CELL_AW-1:0]   clr_addr_q, clr_addr_d;

    logic                 we;
    logic [CELL_AW-1:0]   waddr;
    logic [CELL_W-1:0]    wdata;

    assign rx_rise = rx_valid_i & ~rx_valid_q;

    always_comb begin
        state_d    = state_q;
        cur_col_d  = cur_col_q;
        cur_row_d  = cur_row_q;
        cur_attr_d = cur_attr_q;
        err_d      = err_q;
        op_col_d   = op_col_q;
        op_row_d   = op_row_q;
        op_chr_d   = op_chr_q;
        clr_addr_d = clr_addr_q;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        if (rx_rise && state_q == S_CLEAR) begin
            err_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (rx_rise) begin
                    case (rx_data_i)
                        OP_WRITE: state_d = S_W_COL;
                        OP_PUT:   state_d = S_P_CHR;
                        OP_ATTR:  state_d = S_A_ATR;
                        OP_CLEAR: begin
                            state_d    = S_CLEAR;
                            clr_addr_d = '0;
                        end
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            S_W_COL: begin
                if (rx_rise) begin
                    op_col_d = rx_data_i;
                    state_d  = S_W_ROW;
                end
            end
            S_W_ROW: begin
                if (rx_rise) begin
                    op_row_d = rx_data_i;
                    state_d  = S_W_CHR;
                end
            end
            S_W_CHR: begin
                if (rx_rise) begin
                    op_chr_d = rx_data_i[CHAR_WIDTH-1:0];
                    state_d  = S_W_ATR;
                end
            end
            S_W_ATR: begin
                // Out-of-range frames are consumed whole, then dropped
                if (rx_rise) begin
                    state_d = S_IDLE;
                    if (int'(op_col_q) < N_COL && int'(op_row_q) < N_ROW) begin
                        we    = 1'b1;
                        waddr = cell_addr(ROWW'(op_row_q), COLW'(op_col_q));
                        wdata = {rx_data_i, op_chr_q};
                        {cur_row_d, cur_col_d} =
                            next_pos(ROWW'(op_row_q), COLW'(op_col_q));
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_P_CHR: begin
                if (rx_rise) begin
                    we      = 1'b1;
                    waddr   = cell_addr(cur_row_q, cur_col_q);
                    wdata   = {cur_attr_q, rx_data_i[CHAR_WIDTH-1:0]};
                    state_d = S_IDLE;
                    {cur_row_d, cur_col_d} = next_pos(cur_row_q, cur_col_q);
                end
            end
            S_A_ATR: begin
                if (rx_rise) begin
                    cur_attr_d = rx_data_i;
                    state_d    = S_IDLE;
                end
            end
            S_CLEAR: begin
                we         = 1'b1;
                waddr      = clr_addr_q;
                wdata      = {cur_attr_q, CHAR_WIDTH'(SPACE)};
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == CELL_AW'(N_CELLS - 1)) begin
                    state_d   = S_IDLE;
                    cur_col_d = '0;
                    cur_row_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            rx_valid_q <= 1'b0;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
            cur_attr_q <= DEFAULT_ATTR;
            err_q      <= 1'b0;
            op_col_q   <= '0;
            op_row_q   <= '0;
            op_chr_q   <= '0;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= rx_valid_i;
            cur_col_q  <= cur_col_d;
            cur_row_q  <= cur_row_d;
            cur_attr_q <= cur_attr_d;
            err_q      <= err_d;
            op_col_q   <= op_col_d;
            op_row_q   <= op_row_d;
            op_chr_q   <= op_chr_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign busy_o = (state_q == S_CLEAR);
    assign err_o  = err_q;

    logic [CELL_AW-1:0] rd_addr;
    logic [CELL_W-1:0]  cell_rd;

    text_cell_ram #(
        .DEPTH (N_CELLS),
        .AW    (CELL_AW),
        .DW    (CELL_W)
    ) u_cell_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (rd_addr),
        .rdata_o (cell_rd)
    );

    logic [PXW-1:0]         px1_q, px1_d, px2_q, px2_d;
    logic [GW-1:0]          gy1_q, gy1_d;
    logic [7:0]             attr2_q, attr2_d;
    logic                   act1_q, act1_d, act2_q, act2_d, act3_q, act3_d;
    logic                   hs1_q, hs1_d, hs2_q, hs2_d, hs3_q, hs3_d;
    logic                   vs1_q, vs1_d, vs2_q, vs2_d, vs3_q, vs3_d;
    logic [COLOR_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic                   pix_bit;
    logic [11:0]            rgb_sel;

    always_comb begin
        rd_addr = cell_addr(ROWW'(y_i / C_HEIGHT), COLW'(x_i / C_WIDTH));
        px1_d   = PXW'(x_i % C_WIDTH);
        gy1_d   = GW'(y_i % C_HEIGHT);
        act1_d  = active_i;
        hs1_d   = hs_i;
        vs1_d   = vs_i;
        px2_d   = px1_q;
        attr2_d = cell_rd[CELL_W-1 -: 8];
        act2_d  = act1_q;
        hs2_d   = hs1_q;
        vs2_d   = vs1_q;
        act3_d  = act2_q;
        hs3_d   = hs2_q;
        vs3_d   = vs2_q;
        pix_bit = font_row_i[PXW'(C_WIDTH - 1) - px2_q];
        rgb_sel = palette_rgb(pix_bit ? attr2_q[3:0] : attr2_q[7:4]);
        r_d     = act2_q ? chan(rgb_sel[11:8]) : '0;
        g_d     = act2_q ? chan(rgb_sel[7:4])  : '0;
        b_d     = act2_q ? chan(rgb_sel[3:0])  : '0;
    end

    assign font_addr_o = FONT_AW'({cell_rd[CHAR_WIDTH-1:0], gy1_q});

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            px1_q   <= '0;
            gy1_q   <= '0;
            px2_q   <= '0;
            attr2_q <= '0;
            act1_q  <= 1'b0;
            act2_q  <= 1'b0;
            act3_q  <= 1'b0;
            hs1_q   <= 1'b1;
            hs2_q   <= 1'b1;
            hs3_q   <= 1'b1;
            vs1_q   <= 1'b1;
            vs2_q   <= 1'b1;
            vs3_q   <= 1'b1;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            px1_q   <= px1_d;
            gy1_q   <= gy1_d;
            px2_q   <= px2_d;
            attr2_q <= attr2_d;
            act1_q  <= act1_d;
            act2_q  <= act2_d;
            act3_q  <= act3_d;
            hs1_q   <= hs1_d;
            hs2_q   <= hs2_d;
            hs3_q   <= hs3_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            vs3_q   <= vs3_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign r_o  = r_q;
    assign g_o  = g_q;
    assign b_o  = b_q;
    assign de_o = act3_q;
    assign hs_o = hs3_q;
    assign vs_o = vs3_q;

endmodule

// File: tb/tb_text_engine.sv
// Directed bench for text_engine: command protocol, render pipeline
// timing/colours against a simple font model, sync alignment and errors.
module tb_text_engine;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        active, hs, vs;
    logic [10:0] font_addr;
    logic [7:0]  font_row;
    logic [3:0]  r, g, b;
    logic        de, hso, vso, busy, err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    text_engine dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .x_i         (x),
        .y_i         (y),
        .active_i    (active),
        .hs_i        (hs),
        .vs_i        (vs),
        .font_addr_o (font_addr),
        .font_row_i  (font_row),
        .r_o         (r),
        .g_o         (g),
        .b_o         (b),
        .de_o        (de),
        .hs_o        (hso),
        .vs_o        (vso),
        .busy_o      (busy),
        .err_o       (err)
    );

    // Font model: space is blank, otherwise {char low nibble, glyph row}
    function automatic logic [7:0] glyph(input logic [10:0] a);
        if (a[10:4] == 7'h20) return 8'h00;
        return {a[7:4], a[3:0]};
    endfunction

    always_ff @(posedge clk) font_row <= glyph(font_addr);

    typedef struct {
        int         phase;
        logic [9:0] x;
        logic [8:0] y;
        logic       act;
        logic [11:0] rgb;
    } pvec_t;

    pvec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(posedge clk); #1;
        rx_data  = v;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_write(input logic [7:0] c, input logic [7:0] rw,
                              input logic [7:0] ch, input logic [7:0] at);
        send_byte(8'h01);
        send_byte(c);
        send_byte(rw);
        send_byte(ch);
        send_byte(at);
    endtask

    task automatic pixel(input pvec_t v, input string nm);
        @(posedge clk); #1;
        x = v.x;
        y = v.y;
        active = v.act;
        @(posedge clk); #1;
        active = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk(nm, {19'd0, de, r, g, b}, {19'd0, v.act, v.rgb});
    endtask

    task automatic run_phase(input int p);
        foreach (tbl[i]) begin
            if (tbl[i].phase == p) begin
                pixel(tbl[i], $sformatf("pix%0d(%0d,%0d)",
                                        p, tbl[i].x, tbl[i].y));
            end
        end
    endtask

    task automatic do_clear(input logic inject, input string nm);
        int cnt;
        logic first;
        send_byte(8'h04);
        cnt = 0;
        first = 1'b0;
        fork
            begin
                @(negedge clk);
                first = busy;
                while (busy && cnt < 3000) begin
                    cnt++;
                    @(negedge clk);
                end
            end
            begin
                if (inject) begin
                    repeat (50) @(posedge clk);
                    #1;
                    rx_data  = 8'h04;
                    rx_valid = 1'b1;
                    @(posedge clk); #1;
                    rx_valid = 1'b0;
                end
            end
        join
        chk({nm, "_busy_rise"}, 32'(first), 32'd1);
        chk({nm, "_busy_len"}, 32'(cnt), 32'd2400);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic h_a [24];
        logic v_a [24];
        logic a_a [24];

        // After CLEAR with attr 0x0F: blank cells, bg palette[0]
        tbl.push_back('{1, 10'd0,   9'd0,   1'b1, 12'h000});
        tbl.push_back('{1, 10'd639, 9'd479, 1'b1, 12'h000});
        tbl.push_back('{1, 10'd100, 9'd200, 1'b1, 12'h000});
        tbl.push_back('{1, 10'd43,  9'd32,  1'b1, 12'h000});
        tbl.push_back('{1, 10'd43,  9'd32,  1'b0, 12'h000});
        // 'A' at (5,2), attr 0x1E: fg FF5, bg 00A
        tbl.push_back('{2, 10'd40,  9'd32,  1'b1, 12'h00A});
        tbl.push_back('{2, 10'd43,  9'd32,  1'b1, 12'hFF5});
        tbl.push_back('{2, 10'd42,  9'd47,  1'b1, 12'h00A});
        tbl.push_back('{2, 10'd47,  9'd47,  1'b1, 12'hFF5});
        tbl.push_back('{2, 10'd48,  9'd32,  1'b1, 12'h000});
        tbl.push_back('{2, 10'd39,  9'd32,  1'b1, 12'h000});
        tbl.push_back('{2, 10'd43,  9'd31,  1'b1, 12'h000});
        // 81 x 'B' with attr 0x0A: fg 5F5, bg 000
        tbl.push_back('{3, 10'd2,   9'd0,   1'b1, 12'h5F5});
        tbl.push_back('{3, 10'd634, 9'd0,   1'b1, 12'h5F5});
        tbl.push_back('{3, 10'd2,   9'd16,  1'b1, 12'h5F5});
        tbl.push_back('{3, 10'd10,  9'd16,  1'b1, 12'h000});
        tbl.push_back('{3, 10'd0,   9'd0,   1'b1, 12'h000});
        tbl.push_back('{3, 10'd7,   9'd15,  1'b1, 12'h5F5});
        // (78,29) 'B'/0x1E, PUT 'B' at (79,29), wrap, PUT 'A' at (0,0)
        tbl.push_back('{4, 10'd626, 9'd464, 1'b1, 12'hFF5});
        tbl.push_back('{4, 10'd634, 9'd464, 1'b1, 12'h5F5});
        tbl.push_back('{4, 10'd2,   9'd0,   1'b1, 12'h000});
        tbl.push_back('{4, 10'd3,   9'd0,   1'b1, 12'h5F5});
        tbl.push_back('{4, 10'd10,  9'd0,   1'b1, 12'h5F5});
        // Rejected WRITE col=80 leaves (0,3) and cursor cell (1,0) alone
        tbl.push_back('{5, 10'd3,   9'd48,  1'b1, 12'h000});
        tbl.push_back('{5, 10'd10,  9'd0,   1'b1, 12'h5F5});
        // WRITE after reset mid-CLEAR
        tbl.push_back('{6, 10'd43,  9'd32,  1'b1, 12'hFF5});
        tbl.push_back('{6, 10'd40,  9'd32,  1'b1, 12'h00A});

        rstn = 1'b0;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        x = '0;
        y = '0;
        active = 1'b0;
        hs = 1'b1;
        vs = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_hs", 32'(hso), 32'd1);
        chk("rst_vs", 32'(vso), 32'd1);
        chk("rst_rgb", {20'd0, r, g, b}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rstn = 1'b1;

        do_clear(1'b0, "clr1");
        run_phase(1);

        send_write(8'd5, 8'd2, 8'h41, 8'h1E);
        run_phase(2);
        chk("err_after_write", 32'(err), 32'd0);

        do_clear(1'b0, "clr2");
        send_byte(8'h03);
        send_byte(8'h0A);
        for (int i = 0; i < 81; i++) begin
            send_byte(8'h02);
            send_byte(8'h42);
        end
        run_phase(3);

        send_write(8'd78, 8'd29, 8'h42, 8'h1E);
        send_byte(8'h02);
        send_byte(8'h42);
        send_byte(8'h02);
        send_byte(8'h41);
        run_phase(4);

        chk("err_before_bad", 32'(err), 32'd0);
        send_write(8'd80, 8'd2, 8'h41, 8'h1E);
        @(negedge clk);
        chk("err_bad_col", 32'(err), 32'd1);
        run_phase(5);

        for (int i = 0; i < 24; i++) begin
            logic [4:0] iv;
            iv = 5'(i);
            @(posedge clk); #1;
            h_a[i] = iv[1];
            v_a[i] = ~iv[2];
            a_a[i] = iv[0] ^ iv[3];
            hs = h_a[i];
            vs = v_a[i];
            active = a_a[i];
            x = '0;
            y = '0;
            @(negedge clk);
            if (i >= 3) begin
                chk($sformatf("sync_hs%0d", i), 32'(hso), 32'(h_a[i-3]));
                chk($sformatf("sync_vs%0d", i), 32'(vso), 32'(v_a[i-3]));
                chk($sformatf("sync_de%0d", i), 32'(de), 32'(a_a[i-3]));
                if (de == 1'b0) begin
                    chk($sformatf("blank_rgb%0d", i),
                        {20'd0, r, g, b}, 32'd0);
                end
            end
        end
        @(posedge clk); #1;
        hs = 1'b1;
        vs = 1'b1;
        active = 1'b0;

        do_reset();
        chk("err_cleared", 32'(err), 32'd0);
        send_byte(8'h7F);
        @(negedge clk);
        chk("err_bad_op", 32'(err), 32'd1);

        do_reset();
        chk("err_cleared2", 32'(err), 32'd0);
        do_clear(1'b1, "clr_drop");
        chk("err_drop", 32'(err), 32'd1);

        do_reset();
        send_byte(8'h04);
        repeat (1000) @(negedge clk);
        chk("busy_mid_clear", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("busy_abort", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        send_write(8'd5, 8'd2, 8'h41, 8'h1E);
        run_phase(6);
        chk("err_after_abort", 32'(err), 32'd0);
        chk("busy_after_abort", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
